// File: rtl/ser2par_pkg.sv
// Shared accelerator constants, kept identical to the wide-word serializer so
// both ends of the activation/weight path agree on word widths.
package ser2par_pkg;

   localparam int ACC_DWI = 32;
   localparam int ACC_NW  = 7;

endpackage

// File: rtl/ser2par_if.sv
// Streaming handshake bundle between the word source, the packer and the
// PE-array loader.
interface ser2par_if
   import ser2par_pkg::*;
#(
   parameter int DWI = ACC_DWI,
   parameter int NW  = ACC_NW
);

   localparam int DWO = NW * DWI;
   localparam int CW  = $clog2(NW + 1);

   logic           in_valid;
   logic           in_ready;
   logic [DWI-1:0] in_data;
   logic           flush;
   logic           out_valid;
   logic           out_ready;
   logic [DWO-1:0] out_data;
   logic [CW-1:0]  out_nw;
   logic           busy;

   modport master (
      output in_valid, in_data, flush, out_ready,
      input  in_ready, out_valid, out_data, out_nw, busy
   );

   modport slave (
      input  in_valid, in_data, flush, out_ready,
      output in_ready, out_valid, out_data, out_nw, busy
   );

endinterface

// File: rtl/ser2par.sv
// Serial-to-parallel packer: gathers NW input words LSB-first into one wide
// word, with a separate output register so input keeps flowing.
module ser2par
   import ser2par_pkg::*;
#(
   parameter int DWI = ACC_DWI,
   parameter int NW  = ACC_NW
) (
   input  logic      clk,
   input  logic      rst,
   ser2par_if.slave  bus
);

   localparam int DWO = NW * DWI;
   localparam int CW  = $clog2(NW + 1);
   localparam logic [CW-1:0] LAST = CW'(NW - 1);

   logic [DWO-1:0] acc_q, acc_d;
   logic [DWO-1:0] out_q, out_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [CW-1:0]  outNw_q, outNw_d;
   logic           flushPend_q, flushPend_d;
   logic           outValid_q, outValid_d;

   logic           slotFree;
   logic           inReady;
   logic           inFire;
   logic           outFire;
   logic           complete;
   logic           flushReq;
   logic           flushEmit;
   logic           load;
   logic [DWO-1:0] accWith;
   logic [CW-1:0]  effCnt;

   function automatic logic [DWO-1:0] slot_insert(
      input logic [DWO-1:0] a,
      input logic [CW-1:0]  idx,
      input logic [DWI-1:0] w
   );
      logic [DWO-1:0] r;
      r = a;
      r[int'(idx) * DWI +: DWI] = w;
      return r;
   endfunction

   // The incoming word is folded in before any emit decision, so a flush in
   // the same cycle as an accept carries that word along.
   always_comb begin
      slotFree  = !outValid_q || bus.out_ready;
      inReady   = !rst && !flushPend_q && ((cnt_q != LAST) || slotFree);
      inFire    = bus.in_valid && inReady;
      outFire   = outValid_q && bus.out_ready;
      effCnt    = cnt_q + {{(CW-1){1'b0}}, inFire};
      accWith   = inFire ? slot_insert(acc_q, cnt_q, bus.in_data) : acc_q;
      complete  = inFire && (cnt_q == LAST);
      flushReq  = bus.flush || flushPend_q;
      flushEmit = flushReq && (effCnt != '0) && slotFree && !complete;
      load      = complete || flushEmit;

      acc_d       = accWith;
      cnt_d       = effCnt;
      flushPend_d = flushPend_q;
      out_d       = out_q;
      outNw_d     = outNw_q;
      outValid_d  = outValid_q;

      if (outFire) begin
         outValid_d = 1'b0;
      end

      if (load) begin
         out_d       = accWith;
         outNw_d     = effCnt;
         outValid_d  = 1'b1;
         acc_d       = '0;
         cnt_d       = '0;
         flushPend_d = 1'b0;
      end else if (flushReq && (effCnt != '0)) begin
         flushPend_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_q       <= '0;
         cnt_q       <= '0;
         flushPend_q <= 1'b0;
         out_q       <= '0;
         outNw_q     <= '0;
         outValid_q  <= 1'b0;
      end else begin
         acc_q       <= acc_d;
         cnt_q       <= cnt_d;
         flushPend_q <= flushPend_d;
         out_q       <= out_d;
         outNw_q     <= outNw_d;
         outValid_q  <= outValid_d;
      end
   end

   assign bus.in_ready  = inReady;
   assign bus.out_valid = outValid_q;
   assign bus.out_data  = out_q;
   assign bus.out_nw    = outNw_q;
   assign bus.busy      = (cnt_q != '0) || flushPend_q;

endmodule
